// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM refresh engine: state encoding, default
// timing constants and the width of the owed-refresh counter.
package dram_pkg;

   localparam int unsigned DEF_INTERVAL = 500;
   localparam int unsigned DEF_TCSR     = 1;
   localparam int unsigned DEF_TRAS     = 3;
   localparam int unsigned DEF_TRP      = 2;
   localparam int unsigned DEF_MAXPEND  = 4;

   localparam int unsigned PEND_W = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      CAS_LOW = 3'd2,
      RAS_LOW = 3'd3,
      PRECHG  = 3'd4
   } refState_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running interval down-counter. Reloads INTERVAL-1 on reset and when it
// reaches zero; tick is high for the single cycle the counter sits at zero.
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int unsigned INTERVAL = DEF_INTERVAL
) (
   input  logic clk,
   input  logic RESET,
   output logic tick
);

   localparam logic [15:0] RELOAD = 16'(INTERVAL - 1);

   logic [15:0] count;

   // count down, wrapping back to the reload value after the zero cycle
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET)
         count <= RELOAD;
      else if (count == 16'd0)
         count <= RELOAD;
      else
         count <= count - 16'd1;
   end

   assign tick = (count == 16'd0);

endmodule

// File: rtl/dram_refresh.sv
// CAS-before-RAS refresh engine. Counts refresh intervals, tracks owed
// refreshes, requests the DRAM from the access state machine and drives the
// broadcast refresh strobes once granted.
// Optional feature macro: DRAM_REFRESH_URGENT_EN adds the URGENT output.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | nothing owed, REFREQ low, strobes high
// REQ     | refresh owed, REFREQ high, waiting for REFACK
// CAS_LOW | nREFCAS low for TCSR clocks
// RAS_LOW | nREFCAS and nREFRAS low for TRAS clocks (entry = commit)
// PRECHG  | both strobes high for TRP clocks, then chain/REQ/IDLE
module dram_refresh
   import dram_pkg::*;
#(
   parameter int unsigned INTERVAL = DEF_INTERVAL,
   parameter int unsigned TCSR     = DEF_TCSR,
   parameter int unsigned TRAS     = DEF_TRAS,
   parameter int unsigned TRP      = DEF_TRP,
   parameter int unsigned MAXPEND  = DEF_MAXPEND
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              REFACK,
   output logic              REFREQ,
   output logic              nREFRAS,
   output logic              nREFCAS,
   output logic [PEND_W-1:0] PENDING,
   output logic              OVERRUN
`ifdef DRAM_REFRESH_URGENT_EN
   ,
   output logic              URGENT
`endif
);

   localparam logic [2:0]        CSR_LOAD = 3'(TCSR - 1);
   localparam logic [2:0]        RAS_LOAD = 3'(TRAS - 1);
   localparam logic [2:0]        RP_LOAD  = 3'(TRP - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAXPEND);

   refState_t         state;
   refState_t         nextState;
   logic [2:0]        phase;
   logic [2:0]        nextPhase;
   logic              tick;
   logic              commit;
   logic [PEND_W-1:0] pendNext;
   logic              overrunSet;
   logic              reqNext;
   logic              rasNext;
   logic              casNext;

   dram_refresh_timer #(
      .INTERVAL (INTERVAL)
   ) uTimer (
      .clk   (clk),
      .RESET (RESET),
      .tick  (tick)
   );

   // next state and phase; the phase counter is reloaded on every timed state entry
   always_comb begin
      nextState = state;
      nextPhase = phase;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (PENDING != '0)
               nextState = REQ;
         end
         REQ: begin
            if (REFACK) begin
               nextState = CAS_LOW;
               nextPhase = CSR_LOAD;
            end
         end
         CAS_LOW: begin
            if (phase == 3'd0) begin
               nextState = RAS_LOW;
               nextPhase = RAS_LOAD;
               commit    = 1'b1;
            end else begin
               nextPhase = phase - 3'd1;
            end
         end
         RAS_LOW: begin
            if (phase == 3'd0) begin
               nextState = PRECHG;
               nextPhase = RP_LOAD;
            end else begin
               nextPhase = phase - 3'd1;
            end
         end
         PRECHG: begin
            if (phase == 3'd0) begin
               if (PENDING == '0) begin
                  nextState = IDLE;
               end else if (REFACK) begin
                  nextState = CAS_LOW;
                  nextPhase = CSR_LOAD;
               end else begin
                  // grant withdrawn mid-sequence: ask again rather than chain
                  nextState = REQ;
               end
            end else begin
               nextPhase = phase - 3'd1;
            end
         end
         default: begin
            nextState = IDLE;
            nextPhase = 3'd0;
         end
      endcase
   end

   // strobe and request levels decoded from the next state so the outputs come straight from flops
   always_comb begin
      reqNext = (nextState != IDLE);
      casNext = !((nextState == CAS_LOW) || (nextState == RAS_LOW));
      rasNext = (nextState != RAS_LOW);
   end

   // owed-refresh bookkeeping; a tick and a commit in the same cycle cancel
   always_comb begin
      pendNext   = PENDING;
      overrunSet = 1'b0;
      if (tick && !commit) begin
         if (PENDING == PEND_MAX)
            overrunSet = 1'b1;
         else
            pendNext = PENDING + PEND_W'(1);
      end else if (commit && !tick) begin
         pendNext = PENDING - PEND_W'(1);
      end
   end

   // state, phase and registered outputs; reset forces strobes high at once
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         phase   <= 3'd0;
         REFREQ  <= 1'b0;
         nREFRAS <= 1'b1;
         nREFCAS <= 1'b1;
         PENDING <= '0;
         OVERRUN <= 1'b0;
      end else begin
         state   <= nextState;
         phase   <= nextPhase;
         REFREQ  <= reqNext;
         nREFRAS <= rasNext;
         nREFCAS <= casNext;
         PENDING <= pendNext;
         OVERRUN <= OVERRUN | overrunSet;
      end
   end

`ifdef DRAM_REFRESH_URGENT_EN
   localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(MAXPEND - 1);

   // early warning to the access state machine when the backlog is nearly full
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET)
         URGENT <= 1'b0;
      else
         URGENT <= (PENDING >= PEND_URG);
   end
`endif

endmodule

// File: tb/tb_dram_refresh.sv
// Bench for dram_refresh: a cycle-level reference built from the refresh
// timeline (tick arithmetic, owed count, position within the strobe pattern)
// is compared against every output after every clock edge.
module tb_dram_refresh;

   localparam int INTERVAL = 500;
   localparam int TCSR     = 1;
   localparam int TRAS     = 3;
   localparam int TRP      = 2;
   localparam int MAXPEND  = 4;
   localparam int SEQ_LEN  = TCSR + TRAS + TRP;

   logic       clk = 1'b0;
   logic       RESET = 1'b1;
   logic       REFACK = 1'b0;
   logic       REFREQ;
   logic       nREFRAS;
   logic       nREFCAS;
   logic [2:0] PENDING;
   logic       OVERRUN;
   logic       URGENT;

   int total = 0;
   int bad   = 0;

   // reference state
   int mEdges;     // clock edges since reset release
   int mPend;
   int mStep;      // position in strobe pattern, -1 when not refreshing
   bit mWait;      // requesting, not yet granted
   bit mOver;
   bit mUrg;

   dram_refresh #(
      .INTERVAL (INTERVAL),
      .TCSR     (TCSR),
      .TRAS     (TRAS),
      .TRP      (TRP),
      .MAXPEND  (MAXPEND)
   ) dut (
      .clk     (clk),
      .RESET   (RESET),
      .REFACK  (REFACK),
      .REFREQ  (REFREQ),
      .nREFRAS (nREFRAS),
      .nREFCAS (nREFCAS),
      .PENDING (PENDING),
      .OVERRUN (OVERRUN)
`ifdef DRAM_REFRESH_URGENT_EN
      ,
      .URGENT  (URGENT)
`endif
   );

`ifndef DRAM_REFRESH_URGENT_EN
   assign URGENT = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mEdges = 0;
      mPend  = 0;
      mStep  = -1;
      mWait  = 1'b0;
      mOver  = 1'b0;
      mUrg   = 1'b0;
   endtask

   task automatic modelEdge(input bit ack);
      int pendPre;
      bit tickNow;
      bit commitNow;
      pendPre   = mPend;
      tickNow   = ((mEdges + 1) % INTERVAL) == 0;
      commitNow = (mStep == TCSR - 1);
      if (mStep < 0) begin
         if (!mWait) begin
            if (pendPre != 0) mWait = 1'b1;
         end else if (ack) begin
            mWait = 1'b0;
            mStep = 0;
         end
      end else if (mStep == SEQ_LEN - 1) begin
         if (pendPre == 0) mStep = -1;
         else if (ack) mStep = 0;
         else begin
            mStep = -1;
            mWait = 1'b1;
         end
      end else begin
         mStep++;
      end
      if (tickNow && !commitNow) begin
         if (pendPre == MAXPEND) mOver = 1'b1;
         else mPend++;
      end else if (commitNow && !tickNow) begin
         mPend--;
      end
      mUrg = (pendPre >= MAXPEND - 1);
      mEdges++;
   endtask

   task automatic compareAll();
      bit expCasLow;
      bit expRasLow;
      expCasLow = (mStep >= 0) && (mStep < TCSR + TRAS);
      expRasLow = (mStep >= TCSR) && (mStep < TCSR + TRAS);
      checkVal("REFREQ", 32'(REFREQ), 32'(mWait || (mStep >= 0)));
      checkVal("nREFCAS", 32'(nREFCAS), 32'(!expCasLow));
      checkVal("nREFRAS", 32'(nREFRAS), 32'(!expRasLow));
      checkVal("PENDING", 32'(PENDING), 32'(mPend));
      checkVal("OVERRUN", 32'(OVERRUN), 32'(mOver));
`ifdef DRAM_REFRESH_URGENT_EN
      checkVal("URGENT", 32'(URGENT), 32'(mUrg));
`endif
   endtask

   // one clock: sample REFACK at the edge, advance the reference, compare just after
   task automatic step();
      bit ackS;
      @(posedge clk);
      ackS = REFACK;
      #1;
      modelEdge(ackS);
      compareAll();
   endtask

   // called at posedge+1; leaves reset released just after an edge
   task automatic applyReset();
      RESET = 1'b1;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      compareAll();
      RESET = 1'b0;
   endtask

   task automatic waitRasLow(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (nREFRAS === 1'b0) seen = 1'b1;
      end
      checkVal(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int n;
      bit found;

      // reset, grant tied high: first request timing and one full refresh
      #1;
      applyReset();
      REFACK = 1'b1;
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 700 && !found; i++) begin
         step();
         n++;
         if (REFREQ === 1'b1) found = 1'b1;
      end
      checkVal("firstReqLatency", 32'(n), 32'd501);
      repeat (20) step();
      checkVal("afterFirstReq", 32'(REFREQ), 32'd0);
      checkVal("afterFirstPend", 32'(PENDING), 32'd0);

      // grant withheld: backlog saturates and a tick is lost
      applyReset();
      REFACK = 1'b0;
      repeat (2600) step();
      checkVal("satOverrun", 32'(OVERRUN), 32'd1);
      checkVal("satPending", 32'(PENDING), 32'(MAXPEND));
      REFACK = 1'b1;
      waitRasLow(20, "grantRasWait");
      REFACK = 1'b0;
      repeat (10) step();
      checkVal("dropReqHeld", 32'(REFREQ), 32'd1);
      checkVal("dropPending", 32'(PENDING), 32'(MAXPEND - 1));
      REFACK = 1'b1;
      repeat (30) step();
      checkVal("drainPending", 32'(PENDING), 32'd0);
      checkVal("drainReq", 32'(REFREQ), 32'd0);

      // tick lands on the commit edge with two refreshes owed
      applyReset();
      REFACK = 1'b0;
      repeat (1498) step();
      REFACK = 1'b1;
      step();
      step();
      checkVal("tickOnCommit", 32'(PENDING), 32'd2);
      repeat (100) step();

      // randomized grant behaviour, including misbehaving early drops and idle acks
      for (int i = 0; i < 8000; i++) begin
         if (REFREQ && !REFACK) begin
            if ($urandom_range(3) == 0) REFACK = 1'b1;
         end else if (REFACK && !REFREQ) begin
            if ($urandom_range(1) == 0) REFACK = 1'b0;
         end else if (REFACK && REFREQ) begin
            if ($urandom_range(39) == 0) REFACK = 1'b0;
         end else begin
            if ($urandom_range(49) == 0) REFACK = 1'b1;
         end
         step();
      end

      // asynchronous reset while RAS is low
      REFACK = 1'b1;
      waitRasLow(1200, "rasWaitForReset");
      #2;
      RESET = 1'b1;
      #1;
      checkVal("asyncRstRas", 32'(nREFRAS), 32'd1);
      checkVal("asyncRstCas", 32'(nREFCAS), 32'd1);
      checkVal("asyncRstReq", 32'(REFREQ), 32'd0);
      checkVal("asyncRstPend", 32'(PENDING), 32'd0);
      checkVal("asyncRstOvr", 32'(OVERRUN), 32'd0);
      checkVal("asyncRstUrg", 32'(URGENT), 32'd0);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b0;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
